score_digit_conv: RTL and testbench

- Sits directly upstream of the 4-digit 7-segment scan driver in the Pong display path.
- Takes the left and right player scores as binary values and converts them to four BCD digits with a sequential double-dabble engine.
- Digit order is left tens, left units, right tens, right units.
- The scan driver maps each digit to segment patterns; this block does not drive segments.

---
 rtl/pong_disp_pkg.sv | 21 ++
 rtl/score_digit_conv_if.sv | 26 ++
 rtl/dd_step.sv | 23 ++
 rtl/score_digit_conv.sv | 161 ++++++++++++++++
 tb/tb_score_digit_conv.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pong_disp_pkg.sv
// Shared constants and types for the Pong score display path.
// Consumed by score_digit_conv, its interface and the dd_step helper.
package pong_disp_pkg;

  localparam int SCORE_W = 7;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 7'd99;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam int DD_SHIFTS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Scores above the two-digit range are shown as the largest displayable value.
  function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] s);
    return (s > SCORE_MAX) ? SCORE_MAX : s;
  endfunction

endpackage

// File: rtl/score_digit_conv_if.sv
// Score/digit bundle between the score source, score_digit_conv and the scan driver.
// master drives scores and load; slave (the converter) drives digits and status.
interface score_digit_conv_if;
  import pong_disp_pkg::*;

  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               load;
  logic [3:0]         dig3;
  logic [3:0]         dig2;
  logic [3:0]         dig1;
  logic [3:0]         dig0;
  logic               busy;
  logic               done;

  modport master (
    output score_l, score_r, load,
    input  dig3, dig2, dig1, dig0, busy, done
  );

  modport slave (
    input  score_l, score_r, load,
    output dig3, dig2, dig1, dig0, busy, done
  );

endinterface

// File: rtl/dd_step.sv
// One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift
// the {bcd, bin} pair left by one bit. Purely combinational.
module dd_step
  import pong_disp_pkg::*;
(
  input  logic [7:0]         bcd_in,
  input  logic [SCORE_W-1:0] bin_in,
  output logic [7:0]         bcd_out,
  output logic [SCORE_W-1:0] bin_out
);

  logic [3:0] lo_adj;
  logic [3:0] hi_adj;

  // Nibble correction followed by the one-bit shift of the combined register.
  always_comb begin
    lo_adj  = (bcd_in[3:0] >= 4'd5) ? bcd_in[3:0] + 4'd3 : bcd_in[3:0];
    hi_adj  = (bcd_in[7:4] >= 4'd5) ? bcd_in[7:4] + 4'd3 : bcd_in[7:4];
    bcd_out = {hi_adj[2:0], lo_adj, bin_in[SCORE_W-1]};
    bin_out = {bin_in[SCORE_W-2:0], 1'b0};
  end

endmodule

// File: rtl/score_digit_conv.sv
// Converts left/right binary scores to four BCD digits for the scan driver
// using a sequential double-dabble engine (both players in parallel).
// Optional macro LEADING_ZERO_BLANK_EN: a zero tens digit is written as the
// blank code so the scan driver shows nothing in that position.
module score_digit_conv
  import pong_disp_pkg::*;
(
  input  logic                 clk,
  input  logic                 clr_n,
  score_digit_conv_if.slave    bus
);

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [SCORE_W-1:0] bin_l_q, bin_l_d, bin_r_q, bin_r_d;
  logic [7:0]         bcd_l_q, bcd_l_d, bcd_r_q, bcd_r_d;
  logic               pend_q, pend_d;
  logic [SCORE_W-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [3:0]         dig3_q, dig3_d, dig2_q, dig2_d, dig1_q, dig1_d, dig0_q, dig0_d;
  logic               done_q, done_d;

  logic [7:0]         bcd_l_step, bcd_r_step;
  logic [SCORE_W-1:0] bin_l_step, bin_r_step;

  dd_step u_step_l (
    .bcd_in  (bcd_l_q),
    .bin_in  (bin_l_q),
    .bcd_out (bcd_l_step),
    .bin_out (bin_l_step)
  );

  dd_step u_step_r (
    .bcd_in  (bcd_r_q),
    .bin_in  (bin_r_q),
    .bcd_out (bcd_r_step),
    .bin_out (bin_r_step)
  );

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [3:0] tens_code(input logic [3:0] t);
    return (t == 4'd0) ? DIGIT_BLANK : t;
  endfunction
`else
  function automatic logic [3:0] tens_code(input logic [3:0] t);
    return t;
  endfunction
`endif

  // Next-state, datapath and pending-request logic for the conversion FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_l_d  = bin_l_q;
    bin_r_d  = bin_r_q;
    bcd_l_d  = bcd_l_q;
    bcd_r_d  = bcd_r_q;
    pend_d   = pend_q;
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    dig3_d   = dig3_q;
    dig2_d   = dig2_q;
    dig1_d   = dig1_q;
    dig0_d   = dig0_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          state_d = SHIFT;
          cnt_d   = 3'd0;
          bin_l_d = clamp_score(bus.score_l);
          bin_r_d = clamp_score(bus.score_r);
          bcd_l_d = 8'd0;
          bcd_r_d = 8'd0;
        end
      end

      SHIFT: begin
        bin_l_d = bin_l_step;
        bin_r_d = bin_r_step;
        bcd_l_d = bcd_l_step;
        bcd_r_d = bcd_r_step;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'(DD_SHIFTS - 1)) begin
          state_d = DONE;
        end
        if (bus.load) begin
          pend_d   = 1'b1;
          pend_l_d = clamp_score(bus.score_l);
          pend_r_d = clamp_score(bus.score_r);
        end
      end

      DONE: begin
        dig3_d = tens_code(bcd_l_q[7:4]);
        dig2_d = bcd_l_q[3:0];
        dig1_d = tens_code(bcd_r_q[7:4]);
        dig0_d = bcd_r_q[3:0];
        done_d = 1'b1;
        pend_d = 1'b0;
        if (bus.load || pend_q) begin
          state_d = SHIFT;
          cnt_d   = 3'd0;
          bcd_l_d = 8'd0;
          bcd_r_d = 8'd0;
          bin_l_d = bus.load ? clamp_score(bus.score_l) : pend_l_q;
          bin_r_d = bus.load ? clamp_score(bus.score_r) : pend_r_q;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion and pending request.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      bin_l_q  <= '0;
      bin_r_q  <= '0;
      bcd_l_q  <= 8'd0;
      bcd_r_q  <= 8'd0;
      pend_q   <= 1'b0;
      pend_l_q <= '0;
      pend_r_q <= '0;
      dig3_q   <= 4'd0;
      dig2_q   <= 4'd0;
      dig1_q   <= 4'd0;
      dig0_q   <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_l_q  <= bin_l_d;
      bin_r_q  <= bin_r_d;
      bcd_l_q  <= bcd_l_d;
      bcd_r_q  <= bcd_r_d;
      pend_q   <= pend_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      dig3_q   <= dig3_d;
      dig2_q   <= dig2_d;
      dig1_q   <= dig1_d;
      dig0_q   <= dig0_d;
      done_q   <= done_d;
    end
  end

  assign bus.dig3 = dig3_q;
  assign bus.dig2 = dig2_q;
  assign bus.dig1 = dig1_q;
  assign bus.dig0 = dig0_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_score_digit_conv.sv
// Directed testbench for score_digit_conv; honours LEADING_ZERO_BLANK_EN.
module tb_score_digit_conv;

  logic clk;
  logic clr_n;
  int   n_checks;
  int   n_fail;

  score_digit_conv_if bus ();

  score_digit_conv dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [3:0] tens(input logic [3:0] t);
    return (t == 4'd0) ? 4'hF : t;
  endfunction
`else
  function automatic logic [3:0] tens(input logic [3:0] t);
    return t;
  endfunction
`endif

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
  endfunction

  // Present scores with load for exactly one edge.
  task automatic do_load(input logic [6:0] l, input logic [6:0] r);
    bus.score_l = l;
    bus.score_r = r;
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
  endtask

  // Wait (bounded) for done; report edges waited and busy samples seen before it.
  task automatic wait_done(output int cycles, output int busy_n);
    cycles = 0;
    busy_n = 0;
    while (bus.done !== 1'b1 && cycles < 20) begin
      if (bus.busy === 1'b1) busy_n++;
      tick();
      cycles++;
    end
  endtask

  // Count done pulses over a fixed window.
  task automatic count_done(input int window, output int pulses);
    pulses = 0;
    for (int i = 0; i < window; i++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
  endtask

  initial begin
    int cyc;
    int bsy;
    int pulses;
    n_checks    = 0;
    n_fail      = 0;
    bus.score_l = '0;
    bus.score_r = '0;
    bus.load    = 1'b0;
    clr_n       = 1'b0;

    tick();
    tick();
    chk("reset_digits", 32'(digits()), 32'h0000);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    clr_n = 1'b1;
    tick();

    // Basic conversion 42 / 7
    do_load(7'd42, 7'd7);
    chk("basic_busy_start", 32'(bus.busy), 32'd1);
    wait_done(cyc, bsy);
    chk("basic_latency", 32'(cyc), 32'd8);
    chk("basic_busy_cycles", 32'(bsy), 32'd8);
    chk("basic_digits", 32'(digits()), 32'({4'd4, 4'd2, tens(4'd0), 4'd7}));
    chk("basic_busy_end", 32'(bus.busy), 32'd0);
    tick();
    chk("basic_done_one_cycle", 32'(bus.done), 32'd0);

    // Saturation: 99 stays, 127 clamps to 99
    do_load(7'd99, 7'd127);
    wait_done(cyc, bsy);
    chk("sat_latency", 32'(cyc), 32'd8);
    chk("sat_digits", 32'(digits()), 32'h9999);
    tick();

    // Zero scores
    do_load(7'd0, 7'd0);
    wait_done(cyc, bsy);
    chk("zero_digits", 32'(digits()), 32'({tens(4'd0), 4'd0, tens(4'd0), 4'd0}));
    tick();

    // Pending: two loads during SHIFT, newest wins
    do_load(7'd10, 7'd20);
    tick();
    tick();
    do_load(7'd11, 7'd21);
    tick();
    do_load(7'd12, 7'd22);
    wait_done(cyc, bsy);
    chk("pend_first_latency", 32'(cyc), 32'd3);
    chk("pend_first_digits", 32'(digits()), 32'h1020);
    chk("pend_busy_held", 32'(bus.busy), 32'd1);
    tick();
    wait_done(cyc, bsy);
    chk("pend_second_latency", 32'(cyc), 32'd7);
    chk("pend_second_digits", 32'(digits()), 32'h1222);
    chk("pend_second_idle", 32'(bus.busy), 32'd0);
    count_done(12, pulses);
    chk("pend_no_third", 32'(pulses), 32'd0);

    // Load coincident with the DONE edge overrides pending (33,44)
    do_load(7'd1, 7'd2);
    tick();
    tick();
    do_load(7'd33, 7'd44);
    tick();
    tick();
    tick();
    tick();
    do_load(7'd55, 7'd66);
    chk("dload_done_now", 32'(bus.done), 32'd1);
    chk("dload_first_digits", 32'(digits()), 32'({tens(4'd0), 4'd1, tens(4'd0), 4'd2}));
    tick();
    wait_done(cyc, bsy);
    chk("dload_latency", 32'(cyc), 32'd7);
    chk("dload_digits", 32'(digits()), 32'h5566);
    chk("dload_idle", 32'(bus.busy), 32'd0);
    count_done(12, pulses);
    chk("dload_no_third", 32'(pulses), 32'd0);

    // Output stability while score_l wiggles during SHIFT
    do_load(7'd25, 7'd38);
    for (int i = 0; i < 7; i++) begin
      bus.score_l = 7'($urandom_range(0, 127));
      tick();
      chk("stable_hold", 32'(digits()), 32'h5566);
    end
    tick();
    chk("stable_done", 32'(bus.done), 32'd1);
    chk("stable_digits", 32'(digits()), 32'h2538);
    tick();

    // Reset mid-SHIFT aborts the conversion
    do_load(7'd42, 7'd7);
    tick();
    tick();
    clr_n = 1'b0;
    #1;
    chk("midrst_digits", 32'(digits()), 32'h0000);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    tick();
    clr_n = 1'b1;
    count_done(12, pulses);
    chk("midrst_no_done", 32'(pulses), 32'd0);
    chk("midrst_digits_after", 32'(digits()), 32'h0000);
    chk("midrst_busy_after", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
